image_stat_accum: RTL and testbench

Per-image statistics accumulator that sits directly upstream of the image sorting engine. It consumes the raw 24-bit RGB pixel stream, one image of IMAGE_SIZE×IMAGE_SIZE pixels at a time. For each image it emits one record to the sorter: dominant colour class, image index, and the count and channel sum of the pixels in that class. It applies backpressure to the pixel source through `busy` whenever its single output record slot cannot absorb a finished image.

---
 rtl/image_stat_accum.sv | 81 ++++++++
 tb/tb_image_stat_accum.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/image_stat_accum.sv
// image_stat_accum: per-image dominant-colour stats; pixel stream in (in_valid, image_in_index, pixel_in, busy back), one record slot out (rec_valid/rec_ready, rec_color, rec_index, rec_count, rec_sum)
module image_stat_accum #(
  parameter int IMAGE_SIZE = 128,
  parameter int CNT_W = 15,
  parameter int SUM_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       image_in_index,
  input  logic [23:0]      pixel_in,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_color,
  output logic [4:0]       rec_index,
  output logic [CNT_W-1:0] rec_count,
  output logic [SUM_W-1:0] rec_sum
);
  localparam int PIX_NUM = IMAGE_SIZE * IMAGE_SIZE;
  typedef enum logic [1:0] {ACC, FIN, HOLD} state_t;
  state_t state;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] cnt [3];
  logic [SUM_W-1:0] sum [3];
  logic [4:0] idx;
  logic [7:0] r, g, b, ch;
  logic [1:0] cls, win;
  logic acc, load;
  always_comb begin
    r = pixel_in[23:16];
    g = pixel_in[15:8];
    b = pixel_in[7:0];
    cls = (r >= g && r >= b) ? 2'd0 : (g >= b) ? 2'd1 : 2'd2;
    ch = cls == 2'd0 ? r : cls == 2'd1 ? g : b;
    win = (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) ? 2'd0 : (cnt[1] >= cnt[2]) ? 2'd1 : 2'd2;
    acc = in_valid && state == ACC;
    load = state != ACC && (!rec_valid || rec_ready);
  end
  assign busy = state != ACC;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACC;
      pix_cnt <= '0;
      idx <= '0;
      rec_valid <= 1'b0;
      rec_color <= '0;
      rec_index <= '0;
      rec_count <= '0;
      rec_sum <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
        sum[i] <= '0;
      end
    end else begin
      if (acc) begin
        cnt[cls] <= cnt[cls] + 1'b1;
        sum[cls] <= sum[cls] + SUM_W'(ch);
        pix_cnt <= pix_cnt + 1'b1;
        if (pix_cnt == '0) idx <= image_in_index;
        if (pix_cnt == CNT_W'(PIX_NUM - 1)) state <= FIN;
      end
      if (load) begin
        rec_valid <= 1'b1;
        rec_color <= win;
        rec_index <= idx;
        rec_count <= cnt[win];
        rec_sum <= sum[win];
        pix_cnt <= '0;
        state <= ACC;
        for (int i = 0; i < 3; i++) begin
          cnt[i] <= '0;
          sum[i] <= '0;
        end
      end else begin
        if (state == FIN) state <= HOLD;
        if (rec_valid && rec_ready) rec_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_image_stat_accum.sv
// tb_image_stat_accum: scoreboard bench for a 2x2 instance and a default 128x128 instance
module tb_image_stat_accum;
  typedef struct packed {
    logic [1:0]  c;
    logic [4:0]  i;
    logic [14:0] n;
    logic [21:0] s;
  } rec_t;
  logic clk = 0;
  logic reset = 1;
  int errors = 0;
  int checks = 0;
  rec_t q_s[$];
  rec_t q_b[$];
  logic        s_valid = 0, s_busy, s_rv, s_rr = 1;
  logic [4:0]  s_idx = 0, s_ri;
  logic [23:0] s_pix = 0;
  logic [1:0]  s_rc;
  logic [2:0]  s_rn;
  logic [10:0] s_rs;
  logic        b_valid = 0, b_busy, b_rv, b_rr = 1;
  logic [4:0]  b_idx = 0, b_ri;
  logic [23:0] b_pix = 0;
  logic [1:0]  b_rc;
  logic [14:0] b_rn;
  logic [21:0] b_rs;
  always #5 clk = ~clk;
  image_stat_accum #(.IMAGE_SIZE(2), .CNT_W(3), .SUM_W(11)) u_s (
    .clk(clk), .reset(reset), .in_valid(s_valid), .image_in_index(s_idx), .pixel_in(s_pix),
    .busy(s_busy), .rec_valid(s_rv), .rec_ready(s_rr), .rec_color(s_rc), .rec_index(s_ri),
    .rec_count(s_rn), .rec_sum(s_rs));
  image_stat_accum u_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .image_in_index(b_idx), .pixel_in(b_pix),
    .busy(b_busy), .rec_valid(b_rv), .rec_ready(b_rr), .rec_color(b_rc), .rec_index(b_ri),
    .rec_count(b_rn), .rec_sum(b_rs));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_s(input logic [1:0] c, input logic [4:0] i, input int n, input int s);
    rec_t r;
    r.c = c; r.i = i; r.n = 15'(n); r.s = 22'(s);
    q_s.push_back(r);
  endtask
  always @(negedge clk) begin
    if (!reset && s_rv && s_rr) begin
      if (q_s.size() == 0) chk("s_unexpected_record", 1, 0);
      else begin
        rec_t e;
        e = q_s.pop_front();
        chk("s_rec_color", 32'(s_rc), 32'(e.c));
        chk("s_rec_index", 32'(s_ri), 32'(e.i));
        chk("s_rec_count", 32'(s_rn), 32'(e.n));
        chk("s_rec_sum", 32'(s_rs), 32'(e.s));
      end
    end
    if (!reset && b_rv && b_rr) begin
      if (q_b.size() == 0) chk("b_unexpected_record", 1, 0);
      else begin
        rec_t e;
        e = q_b.pop_front();
        chk("b_rec_color", 32'(b_rc), 32'(e.c));
        chk("b_rec_index", 32'(b_ri), 32'(e.i));
        chk("b_rec_count", 32'(b_rn), 32'(e.n));
        chk("b_rec_sum", 32'(b_rs), 32'(e.s));
      end
    end
  end
  task automatic drive_s(input logic [4:0] idx, input logic [23:0] px);
    bit ok;
    int t;
    s_valid = 1; s_idx = idx; s_pix = px;
    ok = 0; t = 0;
    while (!ok && t < 50) begin
      @(negedge clk) ok = !s_busy;
      @(posedge clk) #1;
      t++;
    end
    if (!ok) chk("s_accept_timeout", 0, 1);
    s_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk) #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [23:0] p1 [4];
    p1[0] = 24'hFF0000; p1[1] = 24'h00FF00; p1[2] = 24'h0000FF; p1[3] = 24'h808080;
    idle(3);
    @(negedge clk);
    chk("reset_busy", 32'(s_busy), 0);
    chk("reset_rec_valid", 32'(s_rv), 0);
    chk("reset_rec_fields", 32'({s_rc, s_ri, s_rn, s_rs}), 0);
    @(posedge clk) #1 reset = 0;
    push_s(0, 5, 2, 383);
    for (int k = 0; k < 4; k++) drive_s(5, p1[k]);
    @(negedge clk);
    chk("fin_busy", 32'(s_busy), 1);
    chk("fin_rec_valid", 32'(s_rv), 0);
    @(negedge clk);
    chk("load_rec_valid", 32'(s_rv), 1);
    chk("load_busy", 32'(s_busy), 0);
    idle(2);
    push_s(2, 7, 3, 346);
    drive_s(7, 24'h00FF00); drive_s(7, 24'h000A0B); drive_s(7, 24'h000050); drive_s(7, 24'h0000FF);
    push_s(1, 8, 2, 266);
    drive_s(8, 24'h00FF00); drive_s(8, 24'h000B0A); drive_s(8, 24'h000050); drive_s(8, 24'h0000FF);
    idle(4);
    s_rr = 0;
    push_s(2, 1, 4, 204);
    push_s(0, 2, 4, 204);
    for (int k = 0; k < 4; k++) drive_s(1, 24'h112233);
    for (int k = 0; k < 4; k++) drive_s(2, 24'h332211);
    @(negedge clk);
    chk("hold_busy_a", 32'(s_busy), 1);
    chk("hold_rec1_index_a", 32'(s_ri), 1);
    repeat (4) @(negedge clk);
    chk("hold_busy_b", 32'(s_busy), 1);
    chk("hold_rec1_stable", 32'({s_rv, s_rc, s_ri, s_rn, s_rs}), 32'({1'b1, 2'd2, 5'd1, 3'd4, 11'd204}));
    @(posedge clk) #1 s_rr = 1;
    @(posedge clk) #1 s_rr = 0;
    @(negedge clk);
    chk("swap_rec_valid", 32'(s_rv), 1);
    chk("swap_rec_index", 32'(s_ri), 2);
    chk("swap_busy", 32'(s_busy), 0);
    idle(2);
    s_rr = 1;
    idle(2);
    push_s(0, 9, 2, 383);
    for (int k = 0; k < 4; k++) begin
      drive_s(k == 0 ? 5'd9 : 5'(20 + k), p1[k]);
      idle($urandom_range(0, 3));
    end
    idle(4);
    for (int k = 0; k < 3; k++) drive_s(3, 24'h0000FF);
    s_valid = 1; s_idx = 3; s_pix = 24'h0000FF; reset = 1;
    @(posedge clk) #1;
    reset = 0; s_valid = 0;
    @(negedge clk);
    chk("midreset_busy", 32'(s_busy), 0);
    chk("midreset_rec_valid", 32'(s_rv), 0);
    push_s(1, 12, 4, 1020);
    for (int k = 0; k < 4; k++) drive_s(12, 24'h00FF00);
    idle(6);
    chk("s_queue_drained", 32'(q_s.size()), 0);
    q_b.push_back('{c: 2'd2, i: 5'd31, n: 15'd16384, s: 22'd4177920});
    b_valid = 1; b_idx = 31; b_pix = 24'h0000FF;
    repeat (16384) @(posedge clk);
    #1 b_valid = 0;
    idle(6);
    chk("b_queue_drained", 32'(q_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
